// File: rtl/index_register_file.sv
// Parametrised index/loop-counter register file: two combinational read ports, write, in-place increment with wrap flag, and sequential clear sweep.
// Optional macro INDEX_REGISTER_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module index_register_file #(
    parameter int WIDTH = 4,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S,
    input  logic [AW-1:0]    W_ADDR,
    input  logic [WIDTH-1:0] W_DATA,
    input  logic             INC,
    input  logic [AW-1:0]    INC_ADDR,
    input  logic             CLR,
    input  logic [AW-1:0]    RA_ADDR,
    output logic [WIDTH-1:0] RA_DATA,
    input  logic [AW-1:0]    RB_ADDR,
    output logic [WIDTH-1:0] RB_DATA,
    output logic             BUSY,
    output logic             INC_WRAP
);

    localparam int DEPTH = 2**AW;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             inc_wrap_q, inc_wrap_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic             inc_en;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        inc_wrap_d = 1'b0;
        mem_d      = mem_q;
        wr_en      = 1'b0;
        inc_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    wr_en  = S;
                    // A write to the same entry overrides the increment entirely.
                    inc_en = INC && !(S && (W_ADDR == INC_ADDR));
                end
            end
            SWEEP: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (inc_en) begin
            mem_d[INC_ADDR] = mem_q[INC_ADDR] + WIDTH'(1);
            inc_wrap_d      = &mem_q[INC_ADDR];
        end
        if (wr_en) begin
            mem_d[W_ADDR] = W_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            inc_wrap_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            inc_wrap_q <= inc_wrap_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign BUSY     = busy_q;
    assign INC_WRAP = inc_wrap_q;

`ifdef INDEX_REGISTER_FILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok  = S && !busy_q && !CLR;
    assign RA_DATA = (fwd_ok && (RA_ADDR == W_ADDR)) ? W_DATA : mem_q[RA_ADDR];
    assign RB_DATA = (fwd_ok && (RB_ADDR == W_ADDR)) ? W_DATA : mem_q[RB_ADDR];
`else
    assign RA_DATA = mem_q[RA_ADDR];
    assign RB_DATA = mem_q[RB_ADDR];
`endif

endmodule

// File: tb/tb_index_register_file.sv
// Scoreboard bench for index_register_file: driver pushes model expectations, negedge monitor pops and compares.
module tb_index_register_file;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       S = 1'b0, INC = 1'b0, CLR = 1'b0;
    logic [3:0] W_ADDR = '0, W_DATA = '0, INC_ADDR = '0, RA_ADDR = '0, RB_ADDR = '0;
    logic [3:0] RA_DATA, RB_DATA;
    logic       BUSY, INC_WRAP;

    index_register_file #(.WIDTH(4), .AW(4)) dut (
        .CLK(clk), .RST(RST), .S(S), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .INC(INC), .INC_ADDR(INC_ADDR), .CLR(CLR),
        .RA_ADDR(RA_ADDR), .RA_DATA(RA_DATA), .RB_ADDR(RB_ADDR), .RB_DATA(RB_DATA),
        .BUSY(BUSY), .INC_WRAP(INC_WRAP)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain array, remaining-sweep counter, last-wrap flag
    int m_mem [16];
    int m_clear_left;
    bit m_wrap;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_clear_left = 0;
        m_wrap = 1'b0;
    endtask

    task automatic model_edge(input bit s, input int wa, input int wd,
                              input bit inc, input int ia, input bit clr);
        m_wrap = 1'b0;
        if (m_clear_left > 0) begin
            m_mem[16 - m_clear_left] = 0;
            m_clear_left--;
        end else if (clr) begin
            m_clear_left = 16;
        end else begin
            if (inc && !(s && wa == ia)) begin
                m_wrap = (m_mem[ia] == 15);
                m_mem[ia] = (m_mem[ia] + 1) % 16;
            end
            if (s) m_mem[wa] = wd;
        end
    endtask

    function automatic int model_read(input int ra, input bit s, input int wa,
                                      input int wd, input bit clr);
        int v;
        v = m_mem[ra];
`ifdef INDEX_REGISTER_FILE_BYPASS_EN
        if (s && m_clear_left == 0 && !clr && ra == wa) v = wd;
`endif
        return v;
    endfunction

    task automatic step(input string nm, input bit rst_i, input bit s, input int wa,
                        input int wd, input bit inc, input int ia, input bit clr,
                        input int ra, input int rb);
        exp_t e;
        RST = rst_i; S = s; W_ADDR = 4'(wa); W_DATA = 4'(wd);
        INC = inc; INC_ADDR = 4'(ia); CLR = clr; RA_ADDR = 4'(ra); RB_ADDR = 4'(rb);
        if (rst_i) model_reset();
        e.nm   = nm;
        e.ra   = 4'(model_read(ra, s, wa, wd, clr));
        e.rb   = 4'(model_read(rb, s, wa, wd, clr));
        e.busy = (m_clear_left > 0);
        e.wrap = m_wrap;
        q.push_back(e);
        @(posedge clk); #1;
        if (!rst_i) model_edge(s, wa, wd, inc, ia, clr);
    endtask

    task automatic idle_read(input string nm, input int ra, input int rb);
        step(nm, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, ra, rb);
    endtask

    task automatic write(input string nm, input int wa, input int wd);
        step(nm, 1'b0, 1'b1, wa, wd, 1'b0, 0, 1'b0, wa, wa);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (RA_DATA !== e.ra) begin
                errors++;
                $display("FAIL %s RA_DATA actual=%h required=%h addr=%0d", e.nm, RA_DATA, e.ra, RA_ADDR);
            end
            checks++;
            if (RB_DATA !== e.rb) begin
                errors++;
                $display("FAIL %s RB_DATA actual=%h required=%h addr=%0d", e.nm, RB_DATA, e.rb, RB_ADDR);
            end
            checks++;
            if (BUSY !== e.busy) begin
                errors++;
                $display("FAIL %s BUSY actual=%b required=%b", e.nm, BUSY, e.busy);
            end
            checks++;
            if (INC_WRAP !== e.wrap) begin
                errors++;
                $display("FAIL %s INC_WRAP actual=%b required=%b", e.nm, INC_WRAP, e.wrap);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;

        step("reset_hold", 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 15);
        for (int i = 0; i < 16; i++) idle_read("reset_rd", i, 15 - i);

        write("wr3", 3, 'hA);
        idle_read("dual_rd3", 3, 3);
        idle_read("rd4", 4, 3);

        write("wr5", 5, 'hF);
        step("inc5_wrap", 1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b0, 5, 3);
        step("inc5_again", 1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b0, 5, 5);
        idle_read("inc5_after", 5, 5);

        write("wr2", 2, 'h7);
        step("collide", 1'b0, 1'b1, 2, 'h3, 1'b1, 2, 1'b0, 2, 5);
        idle_read("collide_rd", 2, 2);
        step("diff_addr", 1'b0, 1'b1, 7, 'hE, 1'b1, 3, 1'b0, 7, 3);
        idle_read("diff_rd", 7, 3);

        for (int i = 0; i < 16; i++) write("fill", i, (i % 15) + 1);
        step("clr", 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 15);
        for (int i = 0; i < 16; i++)
            step("sweep_busy", 1'b0, 1'b1, 0, 5, 1'b1, 1, 1'b1, i, (i + 1) % 16);
        for (int i = 0; i < 16; i++) idle_read("post_sweep", i, 15 - i);

        for (int i = 0; i < 16; i++) write("refill", i, 15 - i);
        step("clr2", 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 15);
        for (int i = 0; i < 5; i++) idle_read("sweep2", 5, 10);
        step("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 5, 10);
        step("wr_after_rst", 1'b0, 1'b1, 9, 'hC, 1'b0, 0, 1'b0, 9, 14);
        idle_read("rd_after_rst", 9, 14);

        step("bypass6", 1'b0, 1'b1, 6, 'h9, 1'b0, 0, 1'b0, 6, 9);
        idle_read("rd6", 6, 6);

        for (int n = 0; n < 600; n++) begin
            bit r, s, inc, clr;
            int wa, ia;
            r   = ($urandom_range(0, 199) == 0);
            s   = $urandom_range(0, 1);
            inc = $urandom_range(0, 1);
            clr = ($urandom_range(0, 24) == 0);
            wa  = $urandom_range(0, 15);
            ia  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            step("random", r, s, wa, $urandom_range(0, 15), inc, ia, clr,
                 ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15),
                 ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 15));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
